// File: rtl/jogo_pkg.sv
// Shared definitions for the player-input path: FSM state codes, button width
// and the default debounce length used by detector_jogada.
package jogo_pkg;

  localparam int LARGURA_BOTOES         = 4;
  localparam int DEBOUNCE_CICLOS_PADRAO = 4;

  // Codes double as the db_estado value shown on the hexa7seg debug display.
  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    FILTRA_PRESS = 3'd1,
    REGISTRA     = 3'd2,
    ESPERA_SOLTA = 3'd3,
    FILTRA_SOLTA = 3'd4
  } estado_t;

  function automatic logic eh_one_hot(input logic [LARGURA_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer that brings the asynchronous push-buttons into the
// clock domain; both stages clear to 0 on reset.
module sincronizador_2ff #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] estagio1;

  // NOTE: sequential state is written with <= so both stages update from
  // values sampled at the same edge; blocking here would collapse the chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estagio1 <= '0;
      q        <= '0;
    end else begin
      estagio1 <= d;
      q        <= estagio1;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// Conditions the raw board buttons into one single-cycle move event plus the
// registered move code. Optional ECO_LEDS_EN adds the leds_eco echo output.
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LARGURA_BOTOES-1:0] botoes,
  input  logic                      habilita,
  input  logic                      zera_jogada,
  output logic                      jogada_feita,
  output logic                      jogada_invalida,
  output logic [LARGURA_BOTOES-1:0] jogada,
  output logic [2:0]                db_estado
`ifdef ECO_LEDS_EN
  ,
  output logic [LARGURA_BOTOES-1:0] leds_eco
`endif
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CICLOS);
  localparam logic [CNT_W-1:0]  CNT_UM  = CNT_W'(1);

  logic [LARGURA_BOTOES-1:0] s;
  logic [LARGURA_BOTOES-1:0] amostra;
  logic [CNT_W-1:0]          cnt;
  estado_t                   estado;

  sincronizador_2ff #(
    .LARGURA (LARGURA_BOTOES)
  ) u_sincronizador (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado  <= OCIOSO;
      amostra <= '0;
      cnt     <= '0;
      jogada  <= '0;
    end else begin
      // An accept in REGISTRA below overrides this clear in the same cycle.
      if (zera_jogada) jogada <= '0;

      if (!habilita) begin
        // Parking in ESPERA_SOLTA forces a held button to be released first.
        estado <= ESPERA_SOLTA;
      end else begin
        case (estado)
          OCIOSO: begin
            if (s != '0) begin
              estado  <= FILTRA_PRESS;
              amostra <= s;
              cnt     <= CNT_UM;
            end
          end
          FILTRA_PRESS: begin
            if (s == '0) begin
              estado <= OCIOSO;
            end else if (s != amostra) begin
              amostra <= s;
              cnt     <= CNT_UM;
            end else if (cnt == CNT_MAX) begin
              estado <= REGISTRA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REGISTRA: begin
            if (eh_one_hot(amostra)) jogada <= amostra;
            estado <= ESPERA_SOLTA;
          end
          ESPERA_SOLTA: begin
            if (s == '0) begin
              estado <= FILTRA_SOLTA;
              cnt    <= CNT_UM;
            end
          end
          FILTRA_SOLTA: begin
            if (s != '0) begin
              estado <= ESPERA_SOLTA;
            end else if (cnt == CNT_MAX) begin
              estado <= OCIOSO;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

  // Moore decode of the registered state, qualified by habilita so a move is
  // never reported while the control unit has the buttons disabled.
  assign jogada_feita    = habilita && (estado == REGISTRA) &&  eh_one_hot(amostra);
  assign jogada_invalida = habilita && (estado == REGISTRA) && !eh_one_hot(amostra);
  assign db_estado       = estado;

`ifdef ECO_LEDS_EN
  assign leds_eco = ((estado == REGISTRA) || (estado == ESPERA_SOLTA)) ? amostra : '0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada: expected move events go into a
// queue when a press is driven and are matched when the DUT pulses.
module tb_detector_jogada;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] botoes = 4'b0000;
  logic       habilita = 1'b1;
  logic       zera_jogada = 1'b0;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic [3:0] jogada;
  logic [2:0] db_estado;
`ifdef ECO_LEDS_EN
  logic [3:0] leds_eco;
`endif

  detector_jogada #(.DEBOUNCE_CICLOS(D)) dut (
    .clock           (clock),
    .reset           (reset),
    .botoes          (botoes),
    .habilita        (habilita),
    .zera_jogada     (zera_jogada),
    .jogada_feita    (jogada_feita),
    .jogada_invalida (jogada_invalida),
    .jogada          (jogada),
    .db_estado       (db_estado)
`ifdef ECO_LEDS_EN
    ,
    .leds_eco        (leds_eco)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       invalida;
    logic [3:0] jogada;
  } evento_t;

  evento_t    esperado[$];
  int         total = 0;
  int         bad = 0;
  int         n_eventos = 0;
  logic       pendente = 1'b0;
  logic [3:0] jogada_pend = 4'b0000;
  logic [3:0] jogada_modelo = 4'b0000;
  logic       viu_registra = 1'b0;
  logic       viu_ocioso = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard side: every pulse pops one expected event; jogada is checked
  // on the following sample, after the REGISTRA edge has loaded it.
  always @(negedge clock) begin
    if (reset) begin
      pendente = 1'b0;
    end else begin
      if (db_estado == 3'd2) viu_registra = 1'b1;
      if (db_estado == 3'd0) viu_ocioso = 1'b1;
      if (pendente) begin
        check("jogada_apos_evento", 32'(jogada), 32'(jogada_pend));
        pendente = 1'b0;
      end
      if (jogada_feita || jogada_invalida) begin
        n_eventos++;
        if (esperado.size() == 0) begin
          check("evento_inesperado", 32'({jogada_feita, jogada_invalida}), 32'd0);
        end else begin
          evento_t ev;
          ev = esperado.pop_front();
          check("tipo_evento", 32'({jogada_feita, jogada_invalida}),
                ev.invalida ? 32'b01 : 32'b10);
          jogada_pend = ev.jogada;
          pendente = 1'b1;
        end
      end
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic espera_valida(input logic [3:0] b);
    evento_t ev;
    ev.invalida = 1'b0;
    ev.jogada = b;
    jogada_modelo = b;
    esperado.push_back(ev);
  endtask

  task automatic espera_invalida();
    evento_t ev;
    ev.invalida = 1'b1;
    ev.jogada = jogada_modelo;
    esperado.push_back(ev);
  endtask

  task automatic esperar_estado(input logic [2:0] cod, input int limite, input string tag);
    int i;
    for (i = 0; i < limite; i++) begin
      @(negedge clock);
      if (db_estado == cod) break;
    end
    if (i == limite) check(tag, 32'(db_estado), 32'(cod));
  endtask

  task automatic solta_e_espera();
    botoes = 4'b0000;
    ciclos(15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    logic [3:0] chatter [12];
    logic [2:0] db_esp [8];
    db_esp = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3};
    chatter = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000,
                4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};

    // Reset state
    ciclos(3);
    check("reset_jogada", 32'(jogada), 32'd0);
    check("reset_feita", 32'(jogada_feita), 32'd0);
    check("reset_invalida", 32'(jogada_invalida), 32'd0);
    check("reset_estado", 32'(db_estado), 32'd0);
`ifdef ECO_LEDS_EN
    check("reset_leds_eco", 32'(leds_eco), 32'd0);
`endif
    reset = 1'b0;
    ciclos(2);

    // Clean press: pulse exactly after e6, state walk 0->1->2->3
    espera_valida(4'b0100);
    botoes = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check($sformatf("lat_feita_e%0d", i), 32'(jogada_feita), (i == 6) ? 32'd1 : 32'd0);
      check($sformatf("lat_estado_e%0d", i), 32'(db_estado), 32'(db_esp[i]));
`ifdef ECO_LEDS_EN
      check($sformatf("lat_leds_e%0d", i), 32'(leds_eco), (i >= 6) ? 32'h4 : 32'h0);
`endif
    end
    check("jogada_0100", 32'(jogada), 32'h4);
    solta_e_espera();
`ifdef ECO_LEDS_EN
    check("leds_apos_solta", 32'(leds_eco), 32'd0);
`endif
    check("ocioso_apos_solta", 32'(db_estado), 32'd0);

    // Bouncing 0010 (runs of 2) must never reach REGISTRA
    base = n_eventos;
    viu_registra = 1'b0;
    for (int i = 0; i < 20; i++) begin
      botoes = ((i / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
      ciclos(1);
    end
    botoes = 4'b0000;
    ciclos(15);
    check("bounce_sem_registra", 32'(viu_registra), 32'd0);
    check("bounce_sem_evento", 32'(n_eventos - base), 32'd0);

    // Long hold gives exactly one event
    espera_valida(4'b0010);
    botoes = 4'b0010;
    ciclos(100);
    check("hold_um_evento", 32'(n_eventos - base), 32'd1);
    solta_e_espera();

    // Two buttons: invalid pulse, jogada keeps 0010
    base = n_eventos;
    espera_invalida();
    botoes = 4'b0011;
    ciclos(20);
    check("invalida_um_evento", 32'(n_eventos - base), 32'd1);
    check("invalida_mantem", 32'(jogada), 32'h2);
    solta_e_espera();

    // Release chatter keeps the FSM out of OCIOSO; clean release then repress
    base = n_eventos;
    espera_valida(4'b0001);
    botoes = 4'b0001;
    ciclos(15);
    viu_ocioso = 1'b0;
    for (int i = 0; i < 12; i++) begin
      botoes = chatter[i];
      ciclos(1);
    end
    check("chatter_sem_ocioso", 32'(viu_ocioso), 32'd0);
    botoes = 4'b0000;
    ciclos(10);
    check("chatter_volta_ocioso", 32'(db_estado), 32'd0);
    espera_valida(4'b0001);
    botoes = 4'b0001;
    ciclos(15);
    check("repress_dois_eventos", 32'(n_eventos - base), 32'd2);
    solta_e_espera();

    // habilita low while held, then re-enabled: no event until release
    base = n_eventos;
    habilita = 1'b0;
    botoes = 4'b1000;
    ciclos(20);
    check("desabilitado_espera", 32'(db_estado), 32'd3);
    habilita = 1'b1;
    ciclos(20);
    check("reabilita_sem_evento", 32'(n_eventos - base), 32'd0);
    solta_e_espera();
    check("reabilita_ocioso", 32'(db_estado), 32'd0);
    espera_valida(4'b1000);
    botoes = 4'b1000;
    ciclos(15);
    check("reabilita_repress", 32'(n_eventos - base), 32'd1);
    solta_e_espera();

    // zera_jogada alone, then together with an accept
    zera_jogada = 1'b1;
    ciclos(1);
    zera_jogada = 1'b0;
    check("zera_limpa", 32'(jogada), 32'd0);
    jogada_modelo = 4'b0000;
    espera_valida(4'b0100);
    botoes = 4'b0100;
    esperar_estado(3'd2, 20, "timeout_registra_zera");
    zera_jogada = 1'b1;
    ciclos(1);
    zera_jogada = 1'b0;
    check("aceite_vence_zera", 32'(jogada), 32'h4);
    solta_e_espera();

    // Reset asserted while in REGISTRA
    espera_valida(4'b0010);
    botoes = 4'b0010;
    esperar_estado(3'd2, 20, "timeout_registra_reset");
    #1 reset = 1'b1;
    #1;
    check("reset_meio_jogada", 32'(jogada), 32'd0);
    check("reset_meio_feita", 32'(jogada_feita), 32'd0);
    check("reset_meio_invalida", 32'(jogada_invalida), 32'd0);
    check("reset_meio_estado", 32'(db_estado), 32'd0);
    botoes = 4'b0000;
    ciclos(2);
    reset = 1'b0;
    ciclos(5);

    check("fila_vazia", 32'(esperado.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
